// File: rtl/servo_cmd_ramp.sv
// Multi-channel servo command sequencer: decodes direction codes into pulse-width targets,
// slews each channel toward its target once per tick, and runs a timed fire/recoil sequence.
// Build option: define SERVO_RAMP_EN for STEP-limited slewing; otherwise each tick jumps straight to the target.
module servo_cmd_ramp #(
   parameter int N_CH         = 2,
   parameter int VAL_W        = 20,
   parameter int STEP         = 250,
   parameter int TICK_DIV     = 50000,
   parameter int VAL_LEFT     = 45250,
   parameter int VAL_RIGHT    = 15000,
   parameter int VAL_RELEASE  = 75000,
   parameter int VAL_HOLD     = 70000,
   parameter int FIRE_VAL     = 60000,
   parameter int RECOIL_VAL   = 15000,
   parameter int FIRE_TICKS   = 200,
   parameter int RECOIL_TICKS = 200
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*N_CH-1:0]       cmd,
   input  logic                    fire_req,
   output logic [VAL_W*N_CH-1:0]   value,
   output logic [N_CH-1:0]         settled,
   output logic [VAL_W-1:0]        fire_value,
   output logic                    fire_busy
);

   localparam longint VAL_LIM = longint'(1) << VAL_W;
   localparam int     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int     PH_MAX  = (FIRE_TICKS > RECOIL_TICKS) ? FIRE_TICKS : RECOIL_TICKS;
   localparam int     PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   if (STEP <= 0 || TICK_DIV < 1 || FIRE_TICKS < 1 || RECOIL_TICKS < 1 ||
       STEP >= VAL_LIM || VAL_LEFT < 0 || VAL_LEFT >= VAL_LIM ||
       VAL_RIGHT < 0 || VAL_RIGHT >= VAL_LIM || VAL_RELEASE < 0 || VAL_RELEASE >= VAL_LIM ||
       VAL_HOLD < 0 || VAL_HOLD >= VAL_LIM || FIRE_VAL < 0 || FIRE_VAL >= VAL_LIM ||
       RECOIL_VAL < 0 || RECOIL_VAL >= VAL_LIM) begin : g_bad_cfg
      $error("servo_cmd_ramp: illegal parameter set");
   end

   function automatic logic [VAL_W-1:0] decode(input logic [3:0] code);
      case (code)
         4'd1:    return VAL_W'(VAL_LEFT);
         4'd2:    return VAL_W'(VAL_RIGHT);
         4'd5:    return VAL_W'(VAL_RELEASE);
         default: return VAL_W'(VAL_HOLD);
      endcase
   endfunction

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;

   assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)       tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [VAL_W-1:0] tgt;
      logic [VAL_W-1:0] val;
      logic [VAL_W-1:0] val_nxt;

      always_ff @(posedge clk) begin
         if (rst) begin
            tgt <= VAL_W'(VAL_HOLD);
            val <= VAL_W'(VAL_HOLD);
         end else begin
            tgt <= decode(cmd[4*i +: 4]);
            if (tick) val <= val_nxt;
         end
      end

`ifdef SERVO_RAMP_EN
      // Distance is taken one bit wider than the values so the sign never wraps.
      logic signed [VAL_W:0] diff;
      logic        [VAL_W:0] mag;

      always_comb begin
         diff = $signed({1'b0, tgt}) - $signed({1'b0, val});
         mag  = diff[VAL_W] ? $unsigned(-diff) : $unsigned(diff);
         if (mag <= (VAL_W+1)'(STEP)) val_nxt = tgt;
         else if (diff[VAL_W])        val_nxt = val - VAL_W'(STEP);
         else                         val_nxt = val + VAL_W'(STEP);
      end
`else
      assign val_nxt = tgt;
`endif

      assign value[VAL_W*i +: VAL_W] = val;
      assign settled[i]              = (val == tgt);
   end

   typedef enum logic [1:0] {S_IDLE, S_FIRE, S_RECOIL} fire_state_t;

   fire_state_t      state, state_nxt;
   logic             req_q, req_prev;
   logic [PH_W-1:0]  ph_cnt, ph_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         req_q    <= 1'b0;
         req_prev <= 1'b0;
         ph_cnt   <= '0;
      end else begin
         state    <= state_nxt;
         req_q    <= fire_req;
         req_prev <= req_q;
         ph_cnt   <= ph_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      ph_nxt     = ph_cnt;
      fire_value = '0;
      fire_busy  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_q && !req_prev) begin
               state_nxt = S_FIRE;
               ph_nxt    = '0;
            end
         end
         S_FIRE: begin
            fire_value = VAL_W'(FIRE_VAL);
            fire_busy  = 1'b1;
            if (tick) begin
               if (ph_cnt == PH_W'(FIRE_TICKS - 1)) begin
                  state_nxt = S_RECOIL;
                  ph_nxt    = '0;
               end else begin
                  ph_nxt = ph_cnt + 1'b1;
               end
            end
         end
         S_RECOIL: begin
            fire_value = VAL_W'(RECOIL_VAL);
            fire_busy  = 1'b1;
            if (tick) begin
               if (ph_cnt == PH_W'(RECOIL_TICKS - 1)) begin
                  state_nxt = S_IDLE;
                  ph_nxt    = '0;
               end else begin
                  ph_nxt = ph_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_servo_cmd_ramp.sv
// Self-checking bench for servo_cmd_ramp: ramp/jump vectors, overshoot limit, fire sequence, mid-run reset.
// Expected values follow SERVO_RAMP_EN so the bench is meaningful in either build.
module tb_servo_cmd_ramp;

`ifdef SERVO_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [7:0]  cmd;
   logic [7:0]  cmd300;
   logic        fire_req;
   logic [39:0] value;
   logic [1:0]  settled;
   logic [19:0] fire_value;
   logic        fire_busy;
   logic [39:0] value300;
   logic [1:0]  settled300;
   logic [19:0] fire_value300;
   logic        fire_busy300;

   int checks = 0;
   int errors = 0;

   servo_cmd_ramp #(.N_CH(2), .STEP(250), .TICK_DIV(4), .FIRE_TICKS(3), .RECOIL_TICKS(2)) u_dut (
      .clk(clk), .rst(rst), .cmd(cmd), .fire_req(fire_req),
      .value(value), .settled(settled), .fire_value(fire_value), .fire_busy(fire_busy)
   );

   servo_cmd_ramp #(.N_CH(2), .STEP(300), .TICK_DIV(4), .FIRE_TICKS(3), .RECOIL_TICKS(2)) u_dut300 (
      .clk(clk), .rst(rst), .cmd(cmd300), .fire_req(1'b0),
      .value(value300), .settled(settled300), .fire_value(fire_value300), .fire_busy(fire_busy300)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ticks(input int n);
      repeat (4*n) step();
   endtask

   typedef struct {
      logic [3:0] c0;
      logic [3:0] c1;
      int         ticks;
      int         e0;
      int         e1;
      logic [1:0] es;
   } vec_t;

   vec_t tv [11];

   initial begin
      tv[0]  = '{4'd1, 4'd0, 1,  RAMP ? 69750 : 45250, 70000, RAMP ? 2'b10 : 2'b11};
      tv[1]  = '{4'd1, 4'd0, 97, RAMP ? 45500 : 45250, 70000, RAMP ? 2'b10 : 2'b11};
      tv[2]  = '{4'd1, 4'd0, 1,  45250, 70000, 2'b11};
      tv[3]  = '{4'd1, 4'd0, 1,  45250, 70000, 2'b11};
      tv[4]  = '{4'd0, 4'd0, 99, 70000, 70000, 2'b11};
      tv[5]  = '{4'd2, 4'd0, 10, RAMP ? 67500 : 15000, 70000, RAMP ? 2'b10 : 2'b11};
      tv[6]  = '{4'd1, 4'd0, 1,  RAMP ? 67250 : 45250, 70000, RAMP ? 2'b10 : 2'b11};
      tv[7]  = '{4'd1, 4'd0, 88, 45250, 70000, 2'b11};
      tv[8]  = '{4'd1, 4'd5, 19, 45250, RAMP ? 74750 : 75000, RAMP ? 2'b01 : 2'b11};
      tv[9]  = '{4'd1, 4'd5, 1,  45250, 75000, 2'b11};
      tv[10] = '{4'd0, 4'd2, 1,  RAMP ? 45500 : 70000, RAMP ? 74750 : 15000, RAMP ? 2'b00 : 2'b11};

      rst      = 1'b1;
      cmd      = 8'h00;
      cmd300   = 8'h00;
      fire_req = 1'b0;
      repeat (3) step();
      check("reset v0", value[19:0], 70000);
      check("reset v1", value[39:20], 70000);
      check("reset settled", settled, 2'b11);
      check("reset fire_value", fire_value, 0);
      check("reset fire_busy", fire_busy, 0);

      // Overshoot case on the STEP=300 instance: 5000 is not a multiple of 300.
      rst    = 1'b0;
      cmd300 = 8'h50;
      repeat (3) step();
      check("step300 pre-tick v1", value300[39:20], 70000);
      step();
      check("step300 tick1 v1", value300[39:20], RAMP ? 70300 : 75000);
      wait_ticks(15);
      check("step300 tick16 v1", value300[39:20], RAMP ? 74800 : 75000);
      check("step300 tick16 settled", settled300, RAMP ? 2'b01 : 2'b11);
      wait_ticks(1);
      check("step300 tick17 v1", value300[39:20], 75000);
      check("step300 tick17 settled", settled300, 2'b11);
      wait_ticks(1);
      check("step300 tick18 v1", value300[39:20], 75000);
      check("idle v0", value[19:0], 70000);

      for (int i = 0; i < 11; i++) begin
         cmd = {tv[i].c1, tv[i].c0};
         wait_ticks(tv[i].ticks);
         check($sformatf("row%0d v0", i), value[19:0], tv[i].e0);
         check($sformatf("row%0d v1", i), value[39:20], tv[i].e1);
         check($sformatf("row%0d settled", i), settled, tv[i].es);
      end

      // Fire: 1-clk pulse on a tick boundary, second pulse while busy must be ignored.
      cmd      = 8'h00;
      fire_req = 1'b1;
      step();
      fire_req = 1'b0;
      check("fire e1 busy", fire_busy, 0);
      for (int e = 2; e <= 28; e++) begin
         step();
         if (e == 5) fire_req = 1'b1;
         if (e == 6) fire_req = 1'b0;
         check($sformatf("fire e%0d value", e), fire_value,
               (e < 12) ? 60000 : (e < 20) ? 15000 : 0);
         check($sformatf("fire e%0d busy", e), fire_busy, (e < 20) ? 1 : 0);
      end

      // A request held high through the whole sequence must not retrigger.
      fire_req = 1'b1;
      repeat (2) step();
      check("held start busy", fire_busy, 1);
      repeat (18) step();
      check("held end busy", fire_busy, 0);
      repeat (8) step();
      check("held no retrigger", fire_busy, 0);
      fire_req = 1'b0;

      // Reset mid-ramp and mid-fire.
      cmd = 8'h02;
      wait_ticks(5);
      fire_req = 1'b1;
      step();
      fire_req = 1'b0;
      step();
      check("pre-reset busy", fire_busy, 1);
      step();
      rst = 1'b1;
      step();
      check("midrst v0", value[19:0], 70000);
      check("midrst v1", value[39:20], 70000);
      check("midrst settled", settled, 2'b11);
      check("midrst fire_value", fire_value, 0);
      check("midrst fire_busy", fire_busy, 0);
      check("midrst step300 v1", value300[39:20], 70000);
      rst = 1'b0;
      repeat (3) step();
      check("postrst pre-tick v0", value[19:0], 70000);
      step();
      check("postrst tick1 v0", value[19:0], RAMP ? 69750 : 15000);
      check("postrst busy", fire_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/servo_cmd_ramp.md
# servo_cmd_ramp

Multi-channel servo command sequencer that turns per-axis direction codes into PWM pulse-width constants and slews each channel's output toward its target at a fixed step per update tick. It also runs a timed fire/recoil sequence for the trigger servo. It sits between the command sources (manual and auto control) and the PWM generators. It replaces the instantaneous code-to-constant decode with rate-limited, tick-paced outputs.

## Interface

Parameters:
- N_CH, 2: number of slewed axis channels.
- VAL_W, 20: width of every pulse-width value.
- STEP, 250: maximum change per tick, in value units.
- TICK_DIV, 50000: clk cycles per update tick (1 ms at 50 MHz).
- VAL_LEFT, 45250: target for code 1.
- VAL_RIGHT, 15000: target for code 2.
- VAL_RELEASE, 75000: target for code 5.
- VAL_HOLD, 70000: target for all other codes, and the reset value.
- FIRE_VAL, 60000: fire output during the FIRE state.
- RECOIL_VAL, 15000: fire output during the RECOIL state.
- FIRE_TICKS, 200: length of the FIRE state, in ticks.
- RECOIL_TICKS, 200: length of the RECOIL state, in ticks.

Ports:
- clk, input, 1: system clock. This is the only clock.
- rst, input, 1: synchronous reset, active-high.
- cmd, input, 4*N_CH: per-channel direction code. Channel i uses bits [4i+3:4i].
- fire_req, input, 1: fire request. Its rising edge starts a sequence.
- value, output, VAL_W*N_CH: slewed pulse width. Channel i uses bits [VAL_W*i+VAL_W-1:VAL_W*i].
- settled, output, N_CH: per-channel flag, high when value equals target.
- fire_value, output, VAL_W: trigger servo pulse width.
- fire_busy, output, 1: high while a fire sequence runs.

## Operation

- Target register per channel, updated every clk from the decoded cmd:
  - code 1 -> VAL_LEFT
  - code 2 -> VAL_RIGHT
  - code 5 -> VAL_RELEASE
  - any other code -> VAL_HOLD
- Tick counter counts 0..TICK_DIV-1 and wraps. tick = (count == TICK_DIV-1).
- On tick, each channel's value moves toward its target:
  - d = target - value, computed signed at VAL_W+1 bits, so there is no overflow.
  - If |d| <= STEP, value = target.
  - Otherwise value = value ± STEP.
  - The update never overshoots the target.
- A target change mid-ramp redirects the ramp from the current value at the next tick. There is no reset of the ramp.
- settled[i] = (value_i == target_i), combinational from registers.
- Fire FSM has three states: IDLE, FIRE, RECOIL.
  - IDLE: fire_value = 0, fire_busy = 0. A rising edge of fire_req (registered previous value low, current high) moves to FIRE on the next clk.
  - FIRE: fire_value = FIRE_VAL. Counts FIRE_TICKS ticks, then moves to RECOIL.
  - RECOIL: fire_value = RECOIL_VAL. Counts RECOIL_TICKS ticks, then returns to IDLE.
  - fire_busy = 1 in FIRE and RECOIL.
  - Rising edges of fire_req while busy are ignored and are not queued.
  - A fire_req held high across a return to IDLE does not retrigger. A new rising edge is required.
- Elaboration fails if any constant does not fit VAL_W, or if STEP = 0, or if TICK_DIV < 1.

## Timing

- Reset values:
  - every value = VAL_HOLD
  - every target = VAL_HOLD
  - settled = all ones
  - fire_value = 0
  - fire_busy = 0
  - tick count = 0
  - FSM in IDLE
  - fire_req edge register = 0
- Reset asserted mid-ramp or mid-fire forces all of the above at the next clk edge.
- cmd to target latency is 1 clk. The target to first value change occurs at the next tick edge.
- The first tick after reset release occurs on the TICK_DIV-th clk edge.
- fire_req edge to fire_busy/fire_value change is 2 clk edges: one for the edge register, one for the FSM.
- FIRE lasts from entry until the FIRE_TICKS-th tick edge. The partial tick interval at entry counts toward the first tick.
- A tick and an FSM transition on the same edge are both applied. Channels update independently on the same tick.

## Configuration

- SERVO_RAMP_EN defined: slew limiting by STEP as described above.
- SERVO_RAMP_EN undefined:
  - Each value loads its target directly on every tick, a single-tick jump.
  - STEP is unused.
  - The tick counter, settled behaviour and fire FSM are unchanged.

## Test plan

Bench parameters: TICK_DIV = 4, STEP = 250, FIRE_TICKS = 3, RECOIL_TICKS = 2, N_CH = 2.

- Reset: hold rst 3 clk, cmd = 0 -> both values 70000, settled = 2'b11, fire_value 0, fire_busy 0.
- ch0 cmd = 1, ch1 cmd = 0 -> ch0 reads 69750 after the first tick, reaches 45250 after 99 ticks, and settled[0] rises then. ch1 stays at 70000 throughout.
- STEP = 300, ch1 cmd = 5 -> 16 steps of 300 reach 74800, and the 17th tick lands exactly on 75000 with no overshoot.
- Redirect: ch0 cmd = 2 for 10 ticks (value 67500), then cmd = 1 -> value falls to 45250 with no jump back to 70000.
- Fire: pulse fire_req for 1 clk, pulse again while busy -> fire_value is 60000 for 3 ticks, 15000 for 2 ticks, then 0. Exactly one sequence runs, and fire_busy drops on return to IDLE.
- rst asserted mid-ramp and mid-FIRE -> the next edge restores 70000 / 0 / IDLE. With SERVO_RAMP_EN undefined, cmd = 2 -> value 15000 at the first tick.
